fpu_ftoi_operand_stage: RTL and testbench

//  Issue stage directly upstream of the float-to-int converter. Buffers packed IEEE-754

---
 rtl/fpu_ftoi_operand_stage.sv | 114 +++++++++++
 tb/tb_fpu_ftoi_operand_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_ftoi_operand_stage.sv
// Operand FIFO and unpack stage in front of the float-to-int converter.
// Optional flush-to-zero of denormal head operands: define FPU_FTOI_FTZ_EN.
module fpu_ftoi_operand_stage #(
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 Flush_SI,
  input  logic [31:0]          Operand_a_DI,
  input  logic [TAG_WIDTH-1:0] Tag_DI,
  input  logic                 Valid_SI,
  output logic                 Ready_SO,
  output logic                 Sign_a_DO,
  output logic [7:0]           Exp_a_DO,
  output logic [23:0]          Mant_a_DO,
  output logic [TAG_WIDTH-1:0] Tag_DO,
  output logic                 Valid_SO,
  input  logic                 Ready_SI,
  output logic                 Denorm_SO
);

  localparam int C_OP   = 32;
  localparam int C_EXP  = 8;
  localparam int C_MANT = 23;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [C_OP-1:0]      opMem_q  [DEPTH];
  logic [TAG_WIDTH-1:0] tagMem_q [DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic readyInt, validInt, push, pop;
  logic [C_OP-1:0]      headOp;
  logic [TAG_WIDTH-1:0] headTag;

  // Handshake flags come from registered count only, so Ready_SO never sees Ready_SI.
  assign readyInt = (cnt_q != CNT_FULL);
  assign validInt = (cnt_q != '0);
  assign push     = Valid_SI & readyInt & ~Flush_SI;
  assign pop      = validInt & Ready_SI & ~Flush_SI;
  assign Ready_SO = readyInt;
  assign Valid_SO = validInt;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (Flush_SI) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      cnt_d   = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opMem_q[i]  <= '0;
        tagMem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
      if (push) begin
        opMem_q[wrPtr_q]  <= Operand_a_DI;
        tagMem_q[wrPtr_q] <= Tag_DI;
      end
    end
  end

  assign headOp  = opMem_q[rdPtr_q];
  assign headTag = tagMem_q[rdPtr_q];

  // Storage keeps raw bits; denormal flushing only affects what the converter sees.
  always_comb begin
    Sign_a_DO = 1'b0;
    Exp_a_DO  = '0;
    Mant_a_DO = '0;
    Tag_DO    = '0;
    Denorm_SO = 1'b0;
    if (validInt) begin
      Sign_a_DO = headOp[C_OP-1];
      Exp_a_DO  = headOp[C_OP-2:C_MANT];
      Mant_a_DO = {|headOp[C_OP-2:C_MANT], headOp[C_MANT-1:0]};
      Tag_DO    = headTag;
`ifdef FPU_FTOI_FTZ_EN
      if ((headOp[C_OP-2:C_MANT] == '0) && (headOp[C_MANT-1:0] != '0)) begin
        Mant_a_DO = '0;
        Denorm_SO = 1'b1;
      end
`endif
    end
  end

  logic unusedExpWidth;
  assign unusedExpWidth = (C_EXP == 8);

endmodule

// File: tb/tb_fpu_ftoi_operand_stage.sv
// Scoreboard bench for fpu_ftoi_operand_stage: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fpu_ftoi_operand_stage;

  localparam int DEPTH     = 2;
  localparam int TAG_WIDTH = 4;

  logic                 clk, rst, flushIn, validIn, readyIn;
  logic [31:0]          opIn;
  logic [TAG_WIDTH-1:0] tagIn;
  logic                 readyOut, validOut, signOut, denormOut;
  logic [7:0]           expOut;
  logic [23:0]          mantOut;
  logic [TAG_WIDTH-1:0] tagOut;

  typedef struct {
    int unsigned sign;
    int unsigned expo;
    int unsigned mant;
    int unsigned tag;
    int unsigned denorm;
  } expEntry_t;

  expEntry_t expQ[$];
  int checks = 0;
  int errors = 0;
  bit ftz;

  fpu_ftoi_operand_stage #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flushIn),
    .Operand_a_DI(opIn), .Tag_DI(tagIn), .Valid_SI(validIn), .Ready_SO(readyOut),
    .Sign_a_DO(signOut), .Exp_a_DO(expOut), .Mant_a_DO(mantOut), .Tag_DO(tagOut),
    .Valid_SO(validOut), .Ready_SI(readyIn), .Denorm_SO(denormOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected converter view of an operand, derived from IEEE-754 field arithmetic.
  function automatic expEntry_t makeExp(input logic [31:0] op, input logic [TAG_WIDTH-1:0] tag);
    expEntry_t e;
    int unsigned bits, frac;
    bits     = op;
    frac     = bits % 32'd8388608;
    e.sign   = bits / 32'h8000_0000;
    e.expo   = (bits / 32'd8388608) % 256;
    e.tag    = tag;
    e.denorm = 0;
    if (e.expo != 0)           e.mant = frac + 32'd8388608;
    else if (ftz && frac != 0) begin e.mant = 0; e.denorm = 1; end
    else                       e.mant = frac;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] op, input logic [TAG_WIDTH-1:0] tag,
                               input logic rdy, input logic fl);
    validIn = v;
    opIn    = op;
    tagIn   = tag;
    readyIn = rdy;
    flushIn = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of expected head values, updated on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
    end else if (flushIn) begin
      expQ.delete();
    end else begin
      automatic bit canPush = (expQ.size() < DEPTH);
      if (expQ.size() != 0 && readyIn) void'(expQ.pop_front());
      if (validIn && canPush) expQ.push_back(makeExp(opIn, tagIn));
    end
  end

  // Monitor: compare DUT head against model head mid-cycle.
  always @(negedge clk) begin
    checkOutput("ready", {31'd0, readyOut}, (expQ.size() < DEPTH) ? 32'd1 : 32'd0);
    checkOutput("valid", {31'd0, validOut}, (expQ.size() != 0) ? 32'd1 : 32'd0);
    if (expQ.size() != 0) begin
      checkOutput("sign",   {31'd0, signOut},   expQ[0].sign);
      checkOutput("exp",    {24'd0, expOut},    expQ[0].expo);
      checkOutput("mant",   {8'd0, mantOut},    expQ[0].mant);
      checkOutput("tag",    {28'd0, tagOut},    expQ[0].tag);
      checkOutput("denorm", {31'd0, denormOut}, expQ[0].denorm);
    end else begin
      checkOutput("idleData", {signOut, denormOut, expOut, mantOut[21:0]}, 32'd0);
      checkOutput("idleHi",   {26'd0, mantOut[23:22], tagOut}, 32'd0);
    end
  end

  function automatic logic [31:0] randOp();
    logic [31:0] op;
    op = $urandom;
    case ($urandom_range(0, 7))
      0, 1: op = op & 32'h807F_FFFF;
      2:    op = op & 32'h8000_0000;
      3:    op = op | 32'h7F80_0000;
      default: ;
    endcase
    return op;
  endfunction

  initial begin
`ifdef FPU_FTOI_FTZ_EN
    ftz = 1'b1;
`else
    ftz = 1'b0;
`endif
    rst = 1'b1;
    validIn = 0; readyIn = 0; flushIn = 0; opIn = '0; tagIn = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single operand round trip
    applyStimulus(1, 32'h3FC0_0000, 4'd3, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Backpressure: fill, hold third upstream, then drain
    applyStimulus(1, 32'h4120_0000, 4'd1, 0, 0);
    applyStimulus(1, 32'hC2C8_0000, 4'd2, 0, 0);
    applyStimulus(1, 32'h3F80_0001, 4'd4, 0, 0);
    applyStimulus(1, 32'h3F80_0001, 4'd4, 0, 0);
    applyStimulus(1, 32'h3F80_0001, 4'd4, 1, 0);
    applyStimulus(1, 32'h3F80_0001, 4'd4, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Streaming push+pop with occupancy one
    for (int i = 0; i < 2 * DEPTH + 2; i++)
      applyStimulus(1, 32'h4000_0000 + i, TAG_WIDTH'(i + 5), 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Denormal, signed zero, infinity
    applyStimulus(1, 32'h0000_0001, 4'd6, 0, 0);
    applyStimulus(1, 32'h8000_0000, 4'd7, 1, 0);
    applyStimulus(1, 32'h807F_FFFF, 4'd8, 1, 0);
    applyStimulus(1, 32'hFF80_0000, 4'd9, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Flush while full with both handshakes active
    applyStimulus(1, 32'h3E80_0000, 4'd10, 0, 0);
    applyStimulus(1, 32'h3E00_0000, 4'd11, 0, 0);
    applyStimulus(1, 32'h4480_0000, 4'd12, 1, 1);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(1, 32'h4100_0000, 4'd13, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Asynchronous reset mid-stream
    applyStimulus(1, 32'h4040_0000, 4'd14, 1, 0);
    applyStimulus(1, 32'h4080_0000, 4'd15, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstValid", {31'd0, validOut}, 32'd0);
    checkOutput("rstReady", {31'd0, readyOut}, 32'd1);
    checkOutput("rstData",  {signOut, denormOut, expOut, mantOut[21:0]}, 32'd0);
    checkOutput("rstHi",    {26'd0, mantOut[23:22], tagOut}, 32'd0);
    validIn = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 32'hBF40_0000, 4'd5, 0, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), randOp(), TAG_WIDTH'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);
    applyStimulus(0, 32'h0, 4'd0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
